xprog_loader: RTL

Sequencer that fills the program RAM from a serial byte stream (PS2/UART receiver side) so the controller can boot from RAM (pc MSB = 1).
- Parses a length header, assembles bytes into instruction words and issues one program-RAM data-interface write per word.
- Reports completion or error to the host.
- Owns the program-RAM data port only while busy; outside a load it drives no writes.

---
 rtl/xprog_loader_if.sv | 24 ++
 rtl/xprog_loader.sv | 118 +++++++++++
 2 files changed

// File: rtl/xprog_loader_if.sv
// Byte-stream and program-RAM data-port signals shared between the loader and its environment.
// master = loader side, slave = stream source / RAM side.
interface xprog_loader_if #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 9
);
  logic               byte_valid;
  logic [7:0]         byte_in;
  logic               byte_ready;
  logic               ram_sel;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [INSTR_W-1:0] ram_data;

  modport master (
    input  byte_valid, byte_in,
    output byte_ready, ram_sel, ram_we, ram_addr, ram_data
  );

  modport slave (
    output byte_valid, byte_in,
    input  byte_ready, ram_sel, ram_we, ram_addr, ram_data
  );
endinterface

// File: rtl/xprog_loader.sv
// Fills program RAM from a length-prefixed serial byte stream, one RAM write per assembled word.
// Reports done/error to the host and drives the RAM port only while a load is active.
module xprog_loader #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  xprog_loader_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);
  localparam int BPW   = INSTR_W / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  logic [2:0]         state;
  logic [15:0]        len;
  logic [INSTR_W-1:0] word;
  logic [INSTR_W-1:0] word_next;
  logic [IDX_W-1:0]   byte_idx;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] data_q;
  logic [16:0]        len_lo_ext;
  logic [16:0]        wc_inc_ext;
  logic               xfer;

  assign bus.byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
  assign busy  = bus.byte_ready || (state == WRITE);
  assign done  = (state == DONE);
  assign error = (state == ERR);

  // Write strobes are gated combinationally so an abort/reset in the WRITE cycle never reaches the RAM.
  assign bus.ram_sel  = (state == WRITE) && !abort && !rst;
  assign bus.ram_we   = bus.ram_sel;
  assign bus.ram_addr = addr_q;
  assign bus.ram_data = data_q;

  assign xfer       = bus.byte_valid && bus.byte_ready;
  assign word_next  = (word << 8) | INSTR_W'(bus.byte_in);
  assign len_lo_ext = {1'b0, len[15:8], bus.byte_in};
  assign wc_inc_ext = 17'(word_count) + 17'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      word       <= '0;
      byte_idx   <= '0;
      word_count <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else if (abort) begin
      state    <= IDLE;
      byte_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN_HI;
            word_count <= '0;
            byte_idx   <= '0;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len[15:8] <= bus.byte_in;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len[7:0] <= bus.byte_in;
            if (len_lo_ext == '0)
              state <= DONE;
            else if (len_lo_ext > MAX_LEN)
              state <= ERR;
            else
              state <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            word <= word_next;
            if (byte_idx == IDX_W'(BPW - 1)) begin
              byte_idx <= '0;
              addr_q   <= word_count[ADDR_W-1:0];
              data_q   <= word_next;
              state    <= WRITE;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
        end
        WRITE: begin
          word_count <= word_count + (ADDR_W+1)'(1);
          if (wc_inc_ext == {1'b0, len})
            state <= DONE;
          else
            state <= DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
